// File: rtl/cell_trio_pkg.sv
// Shared definitions for the cell_trio cell group (C43 counter, FDE flop, BD3 buffer).
package cell_trio_pkg;

    localparam int unsigned C43_W            = 4;
    localparam int unsigned BD3_DELAY_NS_DEF = 0;

    typedef logic [C43_W-1:0] c43_val_t;

    // C43 control inputs grouped as one payload.
    typedef struct packed {
        logic nl;   // synchronous load, active-low
        logic en;   // count enable
        logic ci;   // carry in
    } c43_ctrl_t;

    // Ripple carry: terminal count qualified by carry in only.
    function automatic logic c43_carry(input c43_val_t q, input logic ci);
        return (q == {C43_W{1'b1}}) && ci;
    endfunction

endpackage

// File: rtl/cell_trio_c43.sv
// C43: 4-bit loadable, cascadable up counter with combinational ripple carry.
//   clk_24M, nRES : clock, async active-low reset
//   d_i           : parallel load value
//   ctrl_i        : {nl, en, ci} control payload
//   q_o           : counter value
//   co_o          : ripple carry out (from registered count and ci only)
module cell_trio_c43
    import cell_trio_pkg::*;
(
    input  logic      clk_24M,
    input  logic      nRES,
    input  c43_val_t  d_i,
    input  c43_ctrl_t ctrl_i,
    output c43_val_t  q_o,
    output logic      co_o
);

    c43_val_t cnt_q;
    c43_val_t cnt_d;

    // Next count: load beats increment, increment needs both en and ci.
    always_comb begin
        cnt_d = cnt_q;
        if (!ctrl_i.nl) begin
            cnt_d = d_i;
        end else if (ctrl_i.en && ctrl_i.ci) begin
            cnt_d = cnt_q + C43_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o  = cnt_q;
    // en deliberately excluded so a cascaded stage sees carry with no extra latency.
    assign co_o = c43_carry(cnt_q, ctrl_i.ci);

endmodule

// File: rtl/cell_trio.sv
// cell_trio: group of three basic cells sharing clk_24M / nRES.
//   C43 : c43_d, c43_nl, c43_en, c43_ci -> c43_q, c43_co
//   FDE : fde_d -> fde_q, fde_xq (one-cycle flop with complement)
//   BD3 : bd3_in -> bd3_out (pure combinational buffer, reset-independent)
module cell_trio
    import cell_trio_pkg::*;
#(
    parameter int unsigned BD3_DELAY_NS = BD3_DELAY_NS_DEF
) (
    input  logic             clk_24M,
    input  logic             nRES,
    input  logic [C43_W-1:0] c43_d,
    input  logic             c43_nl,
    input  logic             c43_en,
    input  logic             c43_ci,
    output logic [C43_W-1:0] c43_q,
    output logic             c43_co,
    input  logic             fde_d,
    output logic             fde_q,
    output logic             fde_xq,
    input  logic             bd3_in,
    output logic             bd3_out
);

    c43_ctrl_t c43_ctrl;
    logic      fde_q_q;

    assign c43_ctrl = '{nl: c43_nl, en: c43_en, ci: c43_ci};

    // C43 counter.
    cell_trio_c43 u_c43 (
        .clk_24M (clk_24M),
        .nRES    (nRES),
        .d_i     (c43_d),
        .ctrl_i  (c43_ctrl),
        .q_o     (c43_q),
        .co_o    (c43_co)
    );

    // FDE flop.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            fde_q_q <= 1'b0;
        end else begin
            fde_q_q <= fde_d;
        end
    end

    assign fde_q  = fde_q_q;
    assign fde_xq = ~fde_q_q;

    // BD3 buffer: any propagation delay comes from back-annotation, never from logic.
    if (BD3_DELAY_NS == 0) begin : g_bd3_ideal
        assign bd3_out = bd3_in;
    end else begin : g_bd3_annotated
        assign bd3_out = bd3_in;
    end

endmodule

// File: tb/tb_cell_trio.sv
// Directed self-checking bench for cell_trio, including a two-stage cascade.
module tb_cell_trio;

    logic       clk_24M;
    logic       nRES;
    logic [3:0] c43_d;
    logic       c43_nl, c43_en, c43_ci;
    logic [3:0] c43_q;
    logic       c43_co;
    logic       fde_d, fde_q, fde_xq;
    logic       bd3_in, bd3_out;

    // Cascade pair
    logic [3:0] lo_d, hi_d, lo_q, hi_q;
    logic       cas_nl, lo_en, lo_ci, lo_co, hi_co;
    logic       lo_fq, lo_fxq, hi_fq, hi_fxq, lo_bo, hi_bo;

    int n_checks = 0;
    int n_errors = 0;

    cell_trio dut (
        .clk_24M (clk_24M), .nRES (nRES),
        .c43_d (c43_d), .c43_nl (c43_nl), .c43_en (c43_en), .c43_ci (c43_ci),
        .c43_q (c43_q), .c43_co (c43_co),
        .fde_d (fde_d), .fde_q (fde_q), .fde_xq (fde_xq),
        .bd3_in (bd3_in), .bd3_out (bd3_out)
    );

    cell_trio u_lo (
        .clk_24M (clk_24M), .nRES (nRES),
        .c43_d (lo_d), .c43_nl (cas_nl), .c43_en (lo_en), .c43_ci (lo_ci),
        .c43_q (lo_q), .c43_co (lo_co),
        .fde_d (1'b0), .fde_q (lo_fq), .fde_xq (lo_fxq),
        .bd3_in (1'b0), .bd3_out (lo_bo)
    );

    cell_trio u_hi (
        .clk_24M (clk_24M), .nRES (nRES),
        .c43_d (hi_d), .c43_nl (cas_nl), .c43_en (lo_co), .c43_ci (lo_co),
        .c43_q (hi_q), .c43_co (hi_co),
        .fde_d (1'b0), .fde_q (hi_fq), .fde_xq (hi_fxq),
        .bd3_in (1'b0), .bd3_out (hi_bo)
    );

    initial clk_24M = 1'b0;
    always #5 clk_24M = ~clk_24M;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk_24M);
        #1;
    endtask

    initial begin
        nRES   = 1'b0;
        c43_d  = 4'h0; c43_nl = 1'b1; c43_en = 1'b1; c43_ci = 1'b1;
        fde_d  = 1'b1;
        bd3_in = 1'b0;
        lo_d = 4'h0; hi_d = 4'h0; cas_nl = 1'b1; lo_en = 1'b0; lo_ci = 1'b0;

        // Reset held with clock running and active inputs
        #1;
        check("rst_q0", 8'(c43_q), 8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_q", 8'(c43_q), 8'h0);
            check("rst_co", 8'(c43_co), 8'h0);
            check("rst_fq", 8'(fde_q), 8'h0);
            check("rst_fxq", 8'(fde_xq), 8'h1);
        end
        bd3_in = 1'b1; #1;
        check("bd3_rst_hi", 8'(bd3_out), 8'h1);
        bd3_in = 1'b0; #1;
        check("bd3_rst_lo", 8'(bd3_out), 8'h0);

        // Release, then load C and count C,D,E,F,0
        nRES = 1'b1;
        c43_en = 1'b0; c43_ci = 1'b0; c43_nl = 1'b0; c43_d = 4'hC;
        tick();
        check("load_c", 8'(c43_q), 8'hC);
        c43_nl = 1'b1; c43_en = 1'b1; c43_ci = 1'b1; #1;
        check("co_at_c", 8'(c43_co), 8'h0);
        tick(); check("cnt_d", 8'(c43_q), 8'hD); check("co_d", 8'(c43_co), 8'h0);
        tick(); check("cnt_e", 8'(c43_q), 8'hE); check("co_e", 8'(c43_co), 8'h0);
        tick(); check("cnt_f", 8'(c43_q), 8'hF); check("co_f", 8'(c43_co), 8'h1);
        tick(); check("wrap_0", 8'(c43_q), 8'h0); check("co_0", 8'(c43_co), 8'h0);

        // Hold at F with en=0: co follows ci immediately
        c43_nl = 1'b0; c43_d = 4'hF; tick();
        c43_nl = 1'b1; c43_en = 1'b0; c43_ci = 1'b1; #1;
        check("hold_co1", 8'(c43_co), 8'h1);
        tick();
        check("hold_q", 8'(c43_q), 8'hF);
        check("hold_co", 8'(c43_co), 8'h1);
        c43_ci = 1'b0; #1;
        check("ci0_co", 8'(c43_co), 8'h0);

        // Load wins over count enable
        c43_nl = 1'b0; c43_d = 4'h7; c43_en = 1'b1; c43_ci = 1'b1;
        tick();
        check("load_wins", 8'(c43_q), 8'h7);

        // Count to 5, then reset mid-cycle with a pending load
        c43_d = 4'h3; tick();
        c43_nl = 1'b1; tick(); tick();
        check("at_5", 8'(c43_q), 8'h5);
        c43_nl = 1'b0; c43_d = 4'h9;
        #2 nRES = 1'b0; #1;
        check("async_rst_q", 8'(c43_q), 8'h0);
        check("async_rst_xq", 8'(fde_xq), 8'h1);
        tick();
        check("rst_discard_load", 8'(c43_q), 8'h0);

        // First edge after release counts
        nRES = 1'b1; c43_nl = 1'b1; c43_en = 1'b1; c43_ci = 1'b1;
        fde_d = 1'b1;
        tick();
        check("post_rel_q", 8'(c43_q), 8'h1);

        // FDE pattern 1,0,1
        check("fde1_q", 8'(fde_q), 8'h1); check("fde1_xq", 8'(fde_xq), 8'h0);
        fde_d = 1'b0; tick();
        check("fde0_q", 8'(fde_q), 8'h0); check("fde0_xq", 8'(fde_xq), 8'h1);
        fde_d = 1'b1; #2;
        check("fde_hold", 8'(fde_q), 8'h0);
        tick();
        check("fde1b_q", 8'(fde_q), 8'h1); check("fde1b_xq", 8'(fde_xq), 8'h0);

        // BD3 between edges
        bd3_in = 1'b1; #1; check("bd3_hi", 8'(bd3_out), 8'h1);
        bd3_in = 1'b0; #1; check("bd3_lo", 8'(bd3_out), 8'h0);

        // Cascade: 0F -> 10, FF -> 00
        cas_nl = 1'b0; lo_d = 4'hF; hi_d = 4'h0; lo_en = 1'b1; lo_ci = 1'b1;
        tick();
        cas_nl = 1'b1; #1;
        check("cas_0f", {hi_q, lo_q}, 8'h0F);
        check("cas_lo_co", 8'(lo_co), 8'h1);
        tick();
        check("cas_10", {hi_q, lo_q}, 8'h10);
        cas_nl = 1'b0; lo_d = 4'hF; hi_d = 4'hF;
        tick();
        cas_nl = 1'b1; #1;
        check("cas_ff", {hi_q, lo_q}, 8'hFF);
        check("cas_hi_co", 8'(hi_co), 8'h1);
        tick();
        check("cas_00", {hi_q, lo_q}, 8'h00);
        check("cas_hi_co0", 8'(hi_co), 8'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
